// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg
//   Shared definitions for the ID-stage branch sequencing logic.
//   - bctrl_state_t : controller state encoding
//   - REG_W_DEF     : default register index width
//   - ZERO_REG      : index of the hard-wired zero register
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    BCTRL_IDLE = 2'd0,
    BCTRL_HAZ  = 2'd1,
    BCTRL_PEND = 2'd2
  } bctrl_state_t;

  localparam int REG_W_DEF = 5;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/branch_hazard_det.sv
// branch_hazard_det
//   Combinational read-after-write hazard check for the source registers of
//   a branch/jump sitting in ID.
//   Ports:
//     id_valid, id_is_cti      : ID holds a valid branch/jump
//     id_uses_rs, id_uses_rt   : which sources the instruction reads
//     id_rs, id_rt             : source register indices
//     ex_wreg, ex_dest         : EX-stage register write
//     mem_load, mem_dest       : MEM-stage load destination
//     hz                       : operands not yet available
module branch_hazard_det
  import branch_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             id_valid,
  input  logic             id_is_cti,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_wreg,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_load,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hz
);

  logic rs_match;
  logic rt_match;

  // Register 0 is constant, so it can never be the subject of a RAW hazard.
  assign rs_match = (id_rs != REG_W'(ZERO_REG)) &&
                    ((ex_wreg && (ex_dest == id_rs)) || (mem_load && (mem_dest == id_rs)));
  assign rt_match = (id_rt != REG_W'(ZERO_REG)) &&
                    ((ex_wreg && (ex_dest == id_rt)) || (mem_load && (mem_dest == id_rt)));

  assign hz = id_valid && id_is_cti &&
              ((id_uses_rs && rs_match) || (id_uses_rt && rt_match));

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Sequencing controller for the ID-stage branch generator: stalls IF/ID on
//   branch operand hazards, qualifies the taken decision and delivers the PC
//   redirect, holding it across fetch back-pressure.
//   Ports:
//     clk, rst_n                 : clock, async active-low reset
//     id_*                       : ID-stage instruction info
//     ex_wreg/ex_dest            : EX-stage register write
//     mem_load/mem_dest          : MEM-stage load
//     bg_flag/bg_addr            : BranchGen decision and target
//     if_ready                   : fetch accepts a redirect this cycle
//     flush                      : CP0 exception/eret flush
//     stall_pc/stall_if/bubble_ex: hazard stall controls
//     redir_valid/redir_addr     : redirect request to fetch
//     busy                       : controller not idle
//   Optional build macro BRANCH_CTRL_STATS_EN adds stat_taken,
//   stat_not_taken and stat_stall_cyc counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   BCTRL_IDLE | no stall, no pending redirect; resolves branches in ID
//   BCTRL_HAZ  | stalling on a source hazard; resolves once it clears
//   BCTRL_PEND | taken redirect waiting for fetch to accept it
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = REG_W_DEF,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_is_cti,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              ex_wreg,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              mem_load,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              bg_flag,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              if_ready,
  input  logic              flush,
  output logic              stall_pc,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_addr,
  output logic              busy
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken,
  output logic [STAT_W-1:0] stat_stall_cyc
`endif
);

  bctrl_state_t      state;
  bctrl_state_t      state_nxt;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_load;
  logic              hz;
  logic              res;
  logic              taken;

  branch_hazard_det #(.REG_W(REG_W)) u_hazard_det (
    .id_valid   (id_valid),
    .id_is_cti  (id_is_cti),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_wreg    (ex_wreg),
    .ex_dest    (ex_dest),
    .mem_load   (mem_load),
    .mem_dest   (mem_dest),
    .hz         (hz)
  );

  // BranchGen's decision is only meaningful once the operands are valid.
  assign res   = id_valid && id_is_cti && !hz;
  assign taken = res && bg_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BCTRL_IDLE;
      pend_addr <= '0;
    end else begin
      state <= state_nxt;
      if (pend_load) pend_addr <= bg_addr;
    end
  end

  // HAZ resolves exactly like IDLE once hz drops, so both share one arm.
  // In PEND a new cti is a delay-slot branch and is deliberately ignored.
  always_comb begin
    state_nxt = state;
    pend_load = 1'b0;
    if (flush) begin
      state_nxt = BCTRL_IDLE;
    end else begin
      case (state)
        BCTRL_IDLE, BCTRL_HAZ: begin
          if (hz) begin
            state_nxt = BCTRL_HAZ;
          end else if (taken && !if_ready) begin
            state_nxt = BCTRL_PEND;
            pend_load = 1'b1;
          end else begin
            state_nxt = BCTRL_IDLE;
          end
        end
        BCTRL_PEND: begin
          if (if_ready) state_nxt = BCTRL_IDLE;
        end
        default: state_nxt = BCTRL_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    redir_valid = 1'b0;
    redir_addr  = '0;
    if (!flush) begin
      case (state)
        BCTRL_IDLE, BCTRL_HAZ: begin
          if (hz) begin
            stall_pc  = 1'b1;
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (taken && if_ready) begin
            redir_valid = 1'b1;
            redir_addr  = bg_addr;
          end
        end
        BCTRL_PEND: begin
          redir_valid = 1'b1;
          redir_addr  = pend_addr;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != BCTRL_IDLE);

`ifdef BRANCH_CTRL_STATS_EN
  // A resolve only counts where the controller acts on it, i.e. not in PEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
      stat_stall_cyc <= '0;
    end else if (!flush) begin
      if (res && (state != BCTRL_PEND)) begin
        if (bg_flag) stat_taken     <= stat_taken + STAT_W'(1);
        else         stat_not_taken <= stat_not_taken + STAT_W'(1);
      end
      if (stall_pc) stat_stall_cyc <= stat_stall_cyc + STAT_W'(1);
    end
  end
`else
  // STAT_W only sizes the statistics counters; keep it referenced so the
  // parameter list stays identical between builds.
  if (STAT_W < 1) begin : g_stat_w_unused
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int STAT_W = 32;

  // Expected control bits: {stall_pc, stall_if, bubble_ex, redir_valid, busy}
  localparam bit [4:0] O_NONE    = 5'b00000;
  localparam bit [4:0] O_BUSY    = 5'b00001;
  localparam bit [4:0] O_STALL   = 5'b11100;
  localparam bit [4:0] O_STALL_B = 5'b11101;
  localparam bit [4:0] O_RED     = 5'b00010;
  localparam bit [4:0] O_RED_B   = 5'b00011;

  typedef struct {
    string       name;
    bit          cti;
    bit          urs;
    bit          urt;
    bit [4:0]    rs;
    bit [4:0]    rt;
    bit          exw;
    bit [4:0]    exd;
    bit          ml;
    bit [4:0]    md;
    bit          flag;
    bit [31:0]   addr;
    bit          rdy;
    bit          fl;
    bit [36:0]   exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_is_cti, id_uses_rs, id_uses_rt;
  logic [REG_W-1:0]  id_rs, id_rt, ex_dest, mem_dest;
  logic              ex_wreg, mem_load, bg_flag, if_ready, flush;
  logic [ADDR_W-1:0] bg_addr;
  logic              stall_pc, stall_if, bubble_ex, redir_valid, busy;
  logic [ADDR_W-1:0] redir_addr;
`ifdef BRANCH_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_taken, stat_not_taken, stat_stall_cyc;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit [36:0] exp_q[$];
  string     name_q[$];
  vec_t      vecs[$];

  always #5 clk = ~clk;

  branch_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .STAT_W(STAT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_is_cti   (id_is_cti),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_wreg     (ex_wreg),
    .ex_dest     (ex_dest),
    .mem_load    (mem_load),
    .mem_dest    (mem_dest),
    .bg_flag     (bg_flag),
    .bg_addr     (bg_addr),
    .if_ready    (if_ready),
    .flush       (flush),
    .stall_pc    (stall_pc),
    .stall_if    (stall_if),
    .bubble_ex   (bubble_ex),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .busy        (busy)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken),
    .stat_stall_cyc (stat_stall_cyc)
`endif
  );

  function automatic vec_t mk(string nm, bit cti, bit urs, bit urt, bit [4:0] rs, bit [4:0] rt,
                              bit exw, bit [4:0] exd, bit ml, bit [4:0] md, bit flag,
                              bit [31:0] a, bit rdy, bit fl, bit [4:0] o, bit [31:0] oa);
    vec_t v;
    v.name = nm; v.cti = cti; v.urs = urs; v.urt = urt; v.rs = rs; v.rt = rt;
    v.exw = exw; v.exd = exd; v.ml = ml; v.md = md; v.flag = flag; v.addr = a;
    v.rdy = rdy; v.fl = fl; v.exp = {o, oa};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid   = 1'b1;
    id_is_cti  = v.cti;
    id_uses_rs = v.urs;
    id_uses_rt = v.urt;
    id_rs      = v.rs;
    id_rt      = v.rt;
    ex_wreg    = v.exw;
    ex_dest    = v.exd;
    mem_load   = v.ml;
    mem_dest   = v.md;
    bg_flag    = v.flag;
    bg_addr    = v.addr;
    if_ready   = v.rdy;
    flush      = v.fl;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
  endtask

  task automatic drive_quiet(input string nm, input bit [4:0] o);
    id_valid = 0; id_is_cti = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs = 0; id_rt = 0; ex_wreg = 0; ex_dest = 0; mem_load = 0; mem_dest = 0;
    bg_flag = 0; bg_addr = 0; if_ready = 0; flush = 0;
    exp_q.push_back({o, 32'h0});
    name_q.push_back(nm);
  endtask

  task automatic check_out();
    bit [36:0] got, exp;
    string nm;
    got = {stall_pc, stall_if, bubble_ex, redir_valid, busy, redir_addr};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h required an expected entry", got);
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got ctl=%b addr=%h, required ctl=%b addr=%h",
                 nm, got[36:32], got[31:0], exp[36:32], exp[31:0]);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_out();
  endtask

`ifdef BRANCH_CTRL_STATS_EN
  task automatic check_stats(input string nm, input int t, input int nt, input int sc);
    n_vec++;
    if (stat_taken !== STAT_W'(t) || stat_not_taken !== STAT_W'(nt) || stat_stall_cyc !== STAT_W'(sc)) begin
      n_err++;
      $display("FAIL %s: got taken=%0d not_taken=%0d stall=%0d, required %0d %0d %0d",
               nm, stat_taken, stat_not_taken, stat_stall_cyc, t, nt, sc);
    end
  endtask
`endif

  initial begin
    vecs.push_back(mk("beq_taken",        1,1,1,3,4, 0,0,0,0, 1,32'h0040_0020,1,0, O_RED,   32'h0040_0020));
    vecs.push_back(mk("beq_not_taken",    1,1,1,3,4, 0,0,0,0, 0,32'h0040_0040,1,0, O_NONE,  32'h0));
    vecs.push_back(mk("lw_ex_stall",      1,1,1,5,0, 1,5,0,0, 1,32'h0040_0100,1,0, O_STALL, 32'h0));
    vecs.push_back(mk("lw_mem_stall",     1,1,1,5,0, 0,0,1,5, 1,32'h0040_0100,1,0, O_STALL_B,32'h0));
    vecs.push_back(mk("lw_resolve",       1,1,1,5,0, 0,0,0,5, 1,32'h0040_0100,1,0, O_RED_B, 32'h0040_0100));
    vecs.push_back(mk("jr_alu_stall",     1,1,0,7,0, 1,7,0,0, 1,32'h0040_0200,1,0, O_STALL, 32'h0));
    vecs.push_back(mk("jr_resolve",       1,1,0,7,0, 0,0,0,7, 1,32'h0040_0200,1,0, O_RED_B, 32'h0040_0200));
    vecs.push_back(mk("bgtz_r0",          1,1,0,0,0, 1,0,1,0, 0,32'h0040_0240,1,0, O_NONE,  32'h0));
    vecs.push_back(mk("rt_unused",        1,1,0,2,9, 1,9,0,0, 1,32'h0040_0300,1,0, O_RED,   32'h0040_0300));
    vecs.push_back(mk("hz_not_cti",       0,1,1,5,5, 1,5,0,0, 1,32'h0040_0340,1,0, O_NONE,  32'h0));
    vecs.push_back(mk("jal_not_ready",    1,0,0,0,0, 0,0,0,0, 1,32'h0040_0400,0,0, O_NONE,  32'h0));
    vecs.push_back(mk("pend_hold1",       0,0,0,0,0, 0,0,0,0, 0,32'h0,        0,0, O_RED_B, 32'h0040_0400));
    vecs.push_back(mk("pend_cti_ignored", 1,1,1,5,6, 1,5,0,0, 1,32'h0040_9990,0,0, O_RED_B, 32'h0040_0400));
    vecs.push_back(mk("pend_hold3",       0,0,0,0,0, 0,0,0,0, 0,32'h0,        0,0, O_RED_B, 32'h0040_0400));
    vecs.push_back(mk("pend_accept",      0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,0, O_RED_B, 32'h0040_0400));
    vecs.push_back(mk("pend_done",        0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,0, O_NONE,  32'h0));
    vecs.push_back(mk("haz_enter",        1,1,1,5,0, 1,5,0,0, 1,32'h0040_0480,1,0, O_STALL, 32'h0));
    vecs.push_back(mk("flush_haz",        1,1,1,5,0, 1,5,0,0, 1,32'h0040_0480,1,1, O_BUSY,  32'h0));
    vecs.push_back(mk("post_flush_haz",   1,1,1,5,0, 1,5,0,0, 1,32'h0040_0480,1,0, O_STALL, 32'h0));
    vecs.push_back(mk("haz_exit_no_cti",  0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,0, O_BUSY,  32'h0));
    vecs.push_back(mk("pend_enter",       1,1,1,3,4, 0,0,0,0, 1,32'h0040_0500,0,0, O_NONE,  32'h0));
    vecs.push_back(mk("pend_hold",        0,0,0,0,0, 0,0,0,0, 0,32'h0,        0,0, O_RED_B, 32'h0040_0500));
    vecs.push_back(mk("flush_pend",       0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,1, O_BUSY,  32'h0));
    vecs.push_back(mk("post_flush_pend",  0,0,0,0,0, 0,0,0,0, 0,32'h0,        0,0, O_NONE,  32'h0));
    vecs.push_back(mk("flush_idle_taken", 1,1,1,3,4, 0,0,0,0, 1,32'h0040_0540,1,1, O_NONE,  32'h0));
    vecs.push_back(mk("haz_then_pend",    1,1,1,8,0, 1,8,0,0, 1,32'h0040_0600,0,0, O_STALL, 32'h0));
    vecs.push_back(mk("haz_resolve_nrdy", 1,1,1,8,0, 0,0,0,8, 1,32'h0040_0600,0,0, O_BUSY,  32'h0));
    vecs.push_back(mk("pend_from_haz",    0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,0, O_RED_B, 32'h0040_0600));
    vecs.push_back(mk("idle_again",       0,0,0,0,0, 0,0,0,0, 0,32'h0,        1,0, O_NONE,  32'h0));

    rst_n = 1'b0;
    drive_quiet("reset_state", O_NONE);
    @(posedge clk);
    @(negedge clk);
    check_out();
    rst_n = 1'b1;
    drive_quiet("first_cycle_after_reset", O_NONE);
    @(negedge clk);
    check_out();

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset landing between edges while a redirect is pending.
    apply(mk("pre_reset_pend_enter", 1,0,0,0,0, 0,0,0,0, 1,32'h0040_0700,0,0, O_NONE,  32'h0));
    apply(mk("pre_reset_pend_hold",  0,0,0,0,0, 0,0,0,0, 0,32'h0,        0,0, O_RED_B, 32'h0040_0700));
    @(posedge clk);
    #2;
    drive_quiet("async_reset_mid_pend", O_NONE);
    rst_n = 1'b0;
    #1;
    check_out();
`ifdef BRANCH_CTRL_STATS_EN
    check_stats("stats_after_reset", 0, 0, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive_quiet("after_async_reset", O_NONE);
    @(negedge clk);
    check_out();

    // Load-use sequence again from a clean reset so the counters are known.
    apply(vecs[2]);
    apply(vecs[3]);
    apply(vecs[4]);
`ifdef BRANCH_CTRL_STATS_EN
    @(posedge clk);
    #1;
    check_stats("stats_lw_sequence", 1, 0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
